mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequencer that drives a 6:1 multiplexer and reads its output back. On `start` it latches a data word onto the mux data inputs and steps the mux select through channels 0..N_CH-1. It samples the mux output once per channel into a capture word, then pulses `done`. It sits directly upstream (D/s driver) and downstream (O consumer) of the `Six_One_mux` stage and is used for self-test and serial readout.

## Interface
- `N_CH`, default 6: number of mux channels and width of data/capture words.
- `SEL_W`, default 3: select width; must satisfy 2^SEL_W >= N_CH.
- `DWELL`, default 1: clock cycles each select value is held; must be >= 1.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a scan; sampled only while `busy`=0.
- `data_in`  in  N_CH: word to present to the mux; sampled with an accepted `start`.
- `mux_o`  in  1: mux output (O).
- `mux_d`  out  N_CH: latched word driving mux D.
- `mux_s`  out  SEL_W: mux select.
- `busy`  out  1: scan in progress.
- `done`  out  1: one-cycle pulse when the scan completes.
- `cap_out`  out  N_CH: captured word; bit i = `mux_o` sampled while `mux_s`=i.
- `mismatch`  out  1: loop-back compare result (see Configuration).

## Operation
- Two states: IDLE (`busy`=0) and SCAN (`busy`=1).
- IDLE with `start`=1 at an edge:
  - `mux_d`<=`data_in`, `mux_s`<=0, dwell counter<=0, internal shift register cleared.
  - `mismatch`<=0; state goes to SCAN.
- SCAN, each cycle:
  - Dwell counter increments.
  - When the counter reaches DWELL-1, the edge samples `mux_o` into shift-register bit `mux_s`.
  - On that same edge the counter resets and `mux_s` increments.
- At the sampling edge with `mux_s`=N_CH-1:
  - `cap_out` is loaded atomically with the full capture word.
  - `done`<=1, `busy`<=0, `mux_s`<=0; state returns to IDLE.
- `mux_s` never takes values >= N_CH. Values 6 and 7 are never driven for the default configuration.
- `mux_d` holds its value after the scan until the next accepted `start`.
- `cap_out` holds its value until the next scan completes. It never shows a partial word.
- Boundary conditions:
  - `start` while `busy`=1 is ignored, with no effect on the current scan.
  - `start` in the cycle `done`=1 is accepted because `busy`=0 then. This gives back-to-back scans with no idle gap.
  - `data_in` changes during SCAN have no effect.
  - Reset asserted mid-scan aborts immediately: no `done` pulse, and all outputs go to reset values.

## Timing
- Reset values: `mux_d`=0, `mux_s`=0, `busy`=0, `done`=0, `cap_out`=0, `mismatch`=0. State is IDLE.
- `start` accepted at edge k:
  - `busy`=1 and `mux_s`=0 from edge k.
  - Channel i is held for cycles k+i*DWELL .. k+(i+1)*DWELL-1.
  - `mux_o` for channel i is sampled at edge k+(i+1)*DWELL.
- `done`, the `cap_out` update and `busy` falling all occur at edge k+N_CH*DWELL. `done` is high for exactly one cycle.
- Scan latency is N_CH*DWELL cycles: 6 cycles at the defaults.
- `mux_o` is treated as a combinational function of `mux_d`/`mux_s`. It must settle within one cycle, or within DWELL cycles for slower mux paths.

## Configuration
- Macro: `MUX_SCAN_LOOPBACK_CHECK_EN`.
- Defined:
  - At the completion edge, `mismatch`<=(capture word != `mux_d`).
  - The value is held until the next accepted `start` clears it.
- Undefined:
  - `mismatch` is tied to constant 0.
  - No comparator logic is built.
- Scan behaviour is identical in both cases.

## Test plan
- Defaults, ideal mux model, `data_in`=6'b111010, `start` pulse at edge k:
  - `mux_s` steps 0..5 one per cycle.
  - `done`=1 after edge k+6 and `cap_out`=6'b111010.
  - `mismatch`=0 with the macro defined.
- DWELL=2, `data_in`=6'b000100:
  - Each select value is held 2 cycles.
  - `done` comes after edge k+12 and `cap_out`=6'b000100.
- `start` re-pulsed at cycle k+3 of a scan with `data_in`=6'b010101:
  - Ignored; the scan completes with the original word.
  - `mux_d` is unchanged.
- `start` held high continuously, with `data_in` 6'b111010 then 6'b000100:
  - The second scan starts in the `done` cycle.
  - `busy` drops for only that cycle; both `cap_out` values are correct.
- `rst_n` low at cycle k+3 of a scan:
  - All outputs go to 0 asynchronously and no `done` occurs.
  - After release, a new scan works normally.
- Macro defined, mux model with bit 2 stuck at 0, `data_in`=6'b111110:
  - `cap_out`=6'b111010 and `mismatch`=1 until the next `start`.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 6:1 mux through every channel and captures its output word.
// Optional loop-back compare of the captured word against mux_d: MUX_SCAN_LOOPBACK_CHECK_EN.
`default_nettype none

module mux_scan_ctrl #(
  parameter int N_CH  = 6,
  parameter int SEL_W = 3,
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_CH-1:0]  data_in,
  input  logic             mux_o,
  output logic [N_CH-1:0]  mux_d,
  output logic [SEL_W-1:0] mux_s,
  output logic             busy,
  output logic             done,
  output logic [N_CH-1:0]  cap_out,
  output logic             mismatch
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   mux_d_q, mux_d_d;
  logic [SEL_W-1:0]  mux_s_q, mux_s_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]   shift_q, shift_d;
  logic [N_CH-1:0]   cap_q, cap_d;
  logic              done_q, done_d;
  logic [N_CH-1:0]   capture_word;

  // Partial word with the current channel's sample merged in; used both for
  // the running shift register and for the final atomic cap_out load.
  always_comb begin
    capture_word          = shift_q;
    capture_word[mux_s_q] = mux_o;
  end

`ifdef MUX_SCAN_LOOPBACK_CHECK_EN
  logic mismatch_q, mismatch_d;
`endif

  always_comb begin
    state_d = state_q;
    mux_d_d = mux_d_q;
    mux_s_d = mux_s_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    cap_d   = cap_q;
    done_d  = 1'b0;
`ifdef MUX_SCAN_LOOPBACK_CHECK_EN
    mismatch_d = mismatch_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          mux_d_d = data_in;
          mux_s_d = '0;
          cnt_d   = '0;
          shift_d = '0;
`ifdef MUX_SCAN_LOOPBACK_CHECK_EN
          mismatch_d = 1'b0;
`endif
        end
      end
      ST_SCAN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = capture_word;
          if (mux_s_q == SEL_LAST) begin
            cap_d   = capture_word;
            done_d  = 1'b1;
            mux_s_d = '0;
            state_d = ST_IDLE;
`ifdef MUX_SCAN_LOOPBACK_CHECK_EN
            mismatch_d = (capture_word != mux_d_q);
`endif
          end else begin
            mux_s_d = mux_s_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mux_d_q <= '0;
      mux_s_q <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      cap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mux_d_q <= mux_d_d;
      mux_s_q <= mux_s_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      cap_q   <= cap_d;
      done_q  <= done_d;
    end
  end

`ifdef MUX_SCAN_LOOPBACK_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch_q <= 1'b0;
    else        mismatch_q <= mismatch_d;
  end
  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign mux_d   = mux_d_q;
  assign mux_s   = mux_s_q;
  assign busy    = (state_q == ST_SCAN);
  assign done    = done_q;
  assign cap_out = cap_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed checks of mux_scan_ctrl with DWELL=1 and DWELL=2 instances.
`default_nettype none

module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start1, start2;
  logic [5:0] data1, data2;
  logic       mo1, mo2;
  logic [5:0] md1, md2, cap1, cap2;
  logic [2:0] ms1, ms2;
  logic       busy1, busy2, done1, done2, mis1, mis2;
  logic       stuck2;
  int         n_cmp, n_bad;

`ifdef MUX_SCAN_LOOPBACK_CHECK_EN
  localparam logic LB_EN = 1'b1;
`else
  localparam logic LB_EN = 1'b0;
`endif

  mux_scan_ctrl #(.N_CH(6), .SEL_W(3), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data1), .mux_o(mo1),
    .mux_d(md1), .mux_s(ms1), .busy(busy1), .done(done1), .cap_out(cap1), .mismatch(mis1));

  mux_scan_ctrl #(.N_CH(6), .SEL_W(3), .DWELL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .data_in(data2), .mux_o(mo2),
    .mux_d(md2), .mux_s(ms2), .busy(busy2), .done(done2), .cap_out(cap2), .mismatch(mis2));

  // Six_One_mux behavioural model, optional bit-2 stuck-at-0 fault on instance 1
  always_comb begin
    mo1 = 1'b0;
    mo2 = 1'b0;
    if (ms1 < 3'd6) mo1 = md1[ms1] & ~(stuck2 && ms1 == 3'd2);
    if (ms2 < 3'd6) mo2 = md2[ms2];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start1 = 0; start2 = 0; data1 = '0; data2 = '0; stuck2 = 0;
    repeat (2) tick();
    n_cmp++; if ({md1, ms1, busy1, done1, cap1, mis1} !== 16'd0) begin n_bad++; $display("FAIL reset_dut1 got=%h want=0", {md1, ms1, busy1, done1, cap1, mis1}); end
    n_cmp++; if ({md2, ms2, busy2, done2, cap2, mis2} !== 16'd0) begin n_bad++; $display("FAIL reset_dut2 got=%h want=0", {md2, ms2, busy2, done2, cap2, mis2}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset busy got=%b want=0", busy1); end
  endtask

  task automatic test_basic;
    data1 = 6'b111010; start1 = 1;
    tick();
    start1 = 0; data1 = 6'b000000;
    n_cmp++; if ({busy1, ms1, md1} !== {1'b1, 3'd0, 6'b111010}) begin n_bad++; $display("FAIL basic_accept got=%b/%0d/%b want=1/0/111010", busy1, ms1, md1); end
    for (int i = 1; i < 6; i++) begin
      tick();
      n_cmp++; if ({ms1, done1, busy1} !== {3'(i), 1'b0, 1'b1}) begin n_bad++; $display("FAIL basic_step%0d mux_s/done/busy got=%0d/%b/%b want=%0d/0/1", i, ms1, done1, busy1, i); end
    end
    tick();
    n_cmp++; if ({done1, busy1, ms1} !== {1'b1, 1'b0, 3'd0}) begin n_bad++; $display("FAIL basic_done done/busy/mux_s got=%b/%b/%0d want=1/0/0", done1, busy1, ms1); end
    n_cmp++; if (cap1 !== 6'b111010) begin n_bad++; $display("FAIL basic_cap got=%b want=111010", cap1); end
    n_cmp++; if (mis1 !== 1'b0) begin n_bad++; $display("FAIL basic_mismatch got=%b want=0", mis1); end
    tick();
    n_cmp++; if ({done1, md1, cap1} !== {1'b0, 6'b111010, 6'b111010}) begin n_bad++; $display("FAIL basic_hold done/mux_d/cap got=%b/%b/%b want=0/111010/111010", done1, md1, cap1); end
  endtask

  task automatic test_dwell2;
    data2 = 6'b000100; start2 = 1;
    tick();
    start2 = 0;
    for (int c = 1; c < 12; c++) begin
      tick();
      n_cmp++; if ({ms2, done2, busy2} !== {3'(c / 2), 1'b0, 1'b1}) begin n_bad++; $display("FAIL dwell2_cyc%0d mux_s/done/busy got=%0d/%b/%b want=%0d/0/1", c, ms2, done2, busy2, c / 2); end
    end
    tick();
    n_cmp++; if ({done2, busy2, cap2} !== {1'b1, 1'b0, 6'b000100}) begin n_bad++; $display("FAIL dwell2_done done/busy/cap got=%b/%b/%b want=1/0/000100", done2, busy2, cap2); end
    tick();
    n_cmp++; if (done2 !== 1'b0) begin n_bad++; $display("FAIL dwell2_pulse got=%b want=0", done2); end
  endtask

  task automatic test_ignore_start;
    data1 = 6'b111010; start1 = 1;
    tick();
    start1 = 0;
    repeat (2) tick();
    start1 = 1; data1 = 6'b010101;
    tick();
    start1 = 0;
    n_cmp++; if ({busy1, ms1, md1} !== {1'b1, 3'd3, 6'b111010}) begin n_bad++; $display("FAIL ignore_start busy/mux_s/mux_d got=%b/%0d/%b want=1/3/111010", busy1, ms1, md1); end
    repeat (2) tick();
    n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL ignore_early_done got=%b want=0", done1); end
    tick();
    n_cmp++; if ({done1, cap1, md1} !== {1'b1, 6'b111010, 6'b111010}) begin n_bad++; $display("FAIL ignore_done done/cap/mux_d got=%b/%b/%b want=1/111010/111010", done1, cap1, md1); end
    tick();
  endtask

  task automatic test_back_to_back;
    data1 = 6'b111010; start1 = 1;
    tick();
    data1 = 6'b000100;
    repeat (5) tick();
    tick();
    n_cmp++; if ({done1, busy1, cap1, md1} !== {1'b1, 1'b0, 6'b111010, 6'b111010}) begin n_bad++; $display("FAIL b2b_first done/busy/cap/mux_d got=%b/%b/%b/%b want=1/0/111010/111010", done1, busy1, cap1, md1); end
    tick();
    n_cmp++; if ({done1, busy1, ms1, md1} !== {1'b0, 1'b1, 3'd0, 6'b000100}) begin n_bad++; $display("FAIL b2b_restart done/busy/mux_s/mux_d got=%b/%b/%0d/%b want=0/1/0/000100", done1, busy1, ms1, md1); end
    start1 = 0;
    repeat (5) tick();
    tick();
    n_cmp++; if ({done1, cap1} !== {1'b1, 6'b000100}) begin n_bad++; $display("FAIL b2b_second done/cap got=%b/%b want=1/000100", done1, cap1); end
    tick();
  endtask

  task automatic test_reset_mid;
    data1 = 6'b111010; start1 = 1;
    tick();
    start1 = 0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({md1, ms1, busy1, done1, cap1, mis1} !== 16'd0) begin n_bad++; $display("FAIL reset_mid_async got=%h want=0", {md1, ms1, busy1, done1, cap1, mis1}); end
    repeat (5) tick();
    n_cmp++; if ({done1, busy1} !== 2'b00) begin n_bad++; $display("FAIL reset_mid_nodone done/busy got=%b/%b want=0/0", done1, busy1); end
    rst_n = 1'b1;
    tick();
    data1 = 6'b010101; start1 = 1;
    tick();
    start1 = 0;
    repeat (5) tick();
    tick();
    n_cmp++; if ({done1, cap1} !== {1'b1, 6'b010101}) begin n_bad++; $display("FAIL reset_mid_rescan done/cap got=%b/%b want=1/010101", done1, cap1); end
    tick();
  endtask

  task automatic test_stuck;
    stuck2 = 1; data1 = 6'b111110; start1 = 1;
    tick();
    start1 = 0;
    repeat (5) tick();
    tick();
    n_cmp++; if ({done1, cap1} !== {1'b1, 6'b111010}) begin n_bad++; $display("FAIL stuck_cap done/cap got=%b/%b want=1/111010", done1, cap1); end
    n_cmp++; if (mis1 !== LB_EN) begin n_bad++; $display("FAIL stuck_mismatch got=%b want=%b", mis1, LB_EN); end
    repeat (3) tick();
    n_cmp++; if (mis1 !== LB_EN) begin n_bad++; $display("FAIL stuck_mismatch_hold got=%b want=%b", mis1, LB_EN); end
    stuck2 = 0; data1 = 6'b000001; start1 = 1;
    tick();
    start1 = 0;
    n_cmp++; if (mis1 !== 1'b0) begin n_bad++; $display("FAIL stuck_mismatch_clear got=%b want=0", mis1); end
    repeat (5) tick();
    tick();
    n_cmp++; if ({done1, cap1, mis1} !== {1'b1, 6'b000001, 1'b0}) begin n_bad++; $display("FAIL stuck_recover done/cap/mismatch got=%b/%b/%b want=1/000001/0", done1, cap1, mis1); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_dwell2();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_stuck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
